// File: rtl/uart_tx_frame.sv
// UART transmitter with a valid/ready input, 5..8 data bits, optional odd/even
// parity and 1 or 2 stop bits. Every output is a flop; tx idles high.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
  localparam bit ODD_PAR = (PARITY == 1);
  localparam logic [7:0] DMASK = 8'((16'd1 << DATA_BITS) - 16'd1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_frame: CLK_FREQ / BAUD must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   baud_q, baud_n;
  logic [2:0]      bitc_q, bitc_n;
  logic [7:0]      shift_q, shift_n;
  logic            par_q, par_n;
  logic            tx_n, ready_n, busy_n, done_n;
  logic            bit_end;
  logic [7:0]      data_in;

  assign data_in = tx_data & DMASK;
  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bitc_q   <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bitc_q   <= bitc_n;
      shift_q  <= shift_n;
      par_q    <= par_n;
      tx       <= tx_n;
      tx_ready <= ready_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // tx is registered, so each transition loads the level of the bit that starts next
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bitc_n  = bitc_q;
    shift_n = shift_q;
    par_n   = par_q;
    tx_n    = tx;
    ready_n = tx_ready;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    if (state_q != S_IDLE) baud_n = bit_end ? '0 : baud_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        tx_n = 1'b1;
        if (tx_valid && tx_ready) begin
          shift_n = data_in;
          par_n   = ODD_PAR ? ~^data_in : ^data_in;
          state_n = S_START;
          baud_n  = '0;
          bitc_n  = '0;
          tx_n    = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = shift_q[0];
          shift_n = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bitc_q == DATA_LAST) begin
            bitc_n = '0;
            if (HAS_PAR) begin
              state_n = S_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bitc_n  = bitc_q + 3'd1;
            tx_n    = shift_q[0];
            shift_n = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bitc_q == STOP_LAST) begin
            state_n = S_IDLE;
            bitc_n  = '0;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            bitc_n = bitc_q + 3'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bitc_n  = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four parameter variants share one clock; a
// monitor decodes the selected DUT's line period by period against queued frames.
module tb_uart_tx_frame;
  localparam int C = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_w, valid_w, tx_w, ready_w, busy_w, done_w;
  logic [7:0] data_w [4];
  logic [1:0] sel;
  logic       tx_m, ready_m, busy_m, done_m, rst_m;

  assign tx_m    = tx_w[sel];
  assign ready_m = ready_w[sel];
  assign busy_m  = busy_w[sel];
  assign done_m  = done_w[sel];
  assign rst_m   = rst_w[sel];

  uart_tx_frame u0 (.clk(clk), .rst(rst_w[0]), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
                    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.PARITY(1)) u1 (.clk(clk), .rst(rst_w[1]), .tx_data(data_w[1]), .tx_valid(valid_w[1]),
                    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.PARITY(2)) u2 (.clk(clk), .rst(rst_w[2]), .tx_data(data_w[2]), .tx_valid(valid_w[2]),
                    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst_w[3]), .tx_data(data_w[3]),
                    .tx_valid(valid_w[3]), .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]),
                    .tx_done(done_w[3]));

  // bits[i] is the line level during bit period i of the frame (start bit first)
  typedef struct {
    logic [11:0] bits;
    int          flen;
    int          gap;
    bit          abort;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int frames_done = 0;
  int stray_done = 0;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic void expect_frame(input logic [11:0] b, input int flen, input int gap, input bit abort);
    exp_t e;
    e.bits = b; e.flen = flen; e.gap = gap; e.abort = abort;
    sb.push_back(e);
  endfunction

  initial begin : monitor
    exp_t cur;
    bit   in_frame, busy_prev, pbad, hsbad;
    int   k, idle_cnt, pval;
    in_frame = 0; busy_prev = 0; pbad = 0; hsbad = 0;
    k = 0; idle_cnt = 0; pval = 0;
    cur.bits = '0; cur.flen = 0; cur.gap = -1; cur.abort = 0;
    forever begin
      @(negedge clk);
      if (!in_frame) begin
        if (busy_m === 1'b1 && !busy_prev && rst_m === 1'b0) begin
          if (sb.size() == 0) chk("unexpected_frame", 1, 0);
          else begin
            cur = sb.pop_front();
            if (cur.gap >= 0) chk($sformatf("f%0d_idle_gap", frames_done), idle_cnt, cur.gap);
            in_frame = 1; k = 0; pbad = 0; hsbad = 0;
          end
        end else begin
          idle_cnt++;
          if (done_m === 1'b1) stray_done++;
        end
      end
      if (in_frame) begin
        if (rst_m === 1'b1) begin
          chk($sformatf("f%0d_abort_expected", frames_done), int'(cur.abort), 1);
          chk($sformatf("f%0d_abort_outputs", frames_done), int'({tx_m, ready_m, busy_m, done_m}), 4'b1100);
          in_frame = 0; frames_done++; idle_cnt = 0;
        end else if (k < cur.flen) begin
          if (k % C == 0) begin
            pval = int'(tx_m);
            pbad = (tx_m !== 1'b0 && tx_m !== 1'b1);
          end else if (int'(tx_m) != pval || tx_m === 1'bx) pbad = 1;
          if (!(busy_m === 1'b1 && ready_m === 1'b0 && done_m === 1'b0)) hsbad = 1;
          if (k % C == C - 1)
            chk($sformatf("f%0d_bit%0d", frames_done, k / C), pbad ? 2 : pval, int'(cur.bits[k / C]));
          k++;
        end else begin
          chk($sformatf("f%0d_abort_expected", frames_done), int'(cur.abort), 0);
          chk($sformatf("f%0d_handshake_in_frame", frames_done), int'(hsbad), 0);
          chk($sformatf("f%0d_end_outputs", frames_done), int'({tx_m, ready_m, busy_m, done_m}), 4'b1101);
          in_frame = 0; frames_done++; idle_cnt = 1;
        end
      end
      busy_prev = (busy_m === 1'b1);
    end
  end

  // Holds tx_valid until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input int idx, input logic [7:0] d, input bit drop);
    int t;
    bit acc;
    data_w[idx] = d;
    valid_w[idx] = 1'b1;
    acc = 0;
    t = 0;
    while (!acc && t < 6000) begin
      if (ready_w[idx] === 1'b1) begin
        @(posedge clk);
        acc = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!acc) chk("accept_timeout", 1, 0);
    #1;
    if (drop) valid_w[idx] = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < target) chk("frame_timeout", frames_done, target);
  endtask

  initial begin
    int t;
    rst_w = '1;
    valid_w = '0;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) data_w[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rst_state_u%0d", i), int'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 4'b1100);
    rst_w = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("idle_state_u%0d", i), int'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 4'b1100);

    // 8N1 0x55
    sel = 2'd0;
    expect_frame(12'b00_1_01010101_0, 4340, -1, 0);
    send(0, 8'h55, 1);
    wait_frames(1);

    // 8O1 / 8E1 0x07
    @(negedge clk); sel = 2'd1; @(negedge clk);
    expect_frame(12'b0_1_0_00000111_0, 4774, -1, 0);
    send(1, 8'h07, 1);
    wait_frames(2);
    @(negedge clk); sel = 2'd2; @(negedge clk);
    expect_frame(12'b0_1_1_00000111_0, 4774, -1, 0);
    send(2, 8'h07, 1);
    wait_frames(3);

    // 7N2 0xFF: bit 7 never appears
    @(negedge clk); sel = 2'd3; @(negedge clk);
    expect_frame(12'b00_11_1111111_0, 4340, -1, 0);
    send(3, 8'hFF, 1);
    wait_frames(4);

    // back-to-back with tx_valid held
    @(negedge clk); sel = 2'd0; @(negedge clk);
    expect_frame(12'b00_1_10100101_0, 4340, -1, 0);
    expect_frame(12'b00_1_00111100_0, 4340, 1, 0);
    send(0, 8'hA5, 0);
    send(0, 8'h3C, 1);
    wait_frames(6);

    // reset during data bit 3, then a clean frame
    @(negedge clk);
    expect_frame(12'b00_1_10010110_0, 4340, -1, 1);
    send(0, 8'h96, 1);
    repeat (4 * C + 200) @(posedge clk);
    #1 rst_w[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_w[0] = 1'b0;
    wait_frames(7);
    @(negedge clk);
    expect_frame(12'b00_1_01101001_0, 4340, -1, 0);
    send(0, 8'h69, 1);
    wait_frames(8);

    // tx_data scrambled every cycle while the frame is in flight
    @(negedge clk);
    expect_frame(12'b00_1_11000011_0, 4340, -1, 0);
    send(0, 8'hC3, 1);
    t = 0;
    while (frames_done < 9 && t < 6000) begin
      @(negedge clk);
      data_w[0] = 8'($urandom);
      t++;
    end
    if (frames_done < 9) chk("frame_timeout", frames_done, 9);

    repeat (5) @(negedge clk);
    chk("stray_done", stray_done, 0);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
